// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the L1 I-cache refill controller.
// The constants below describe the default configuration (256-bit line, 64-bit beats).
package icache_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    WRITE,
    SETTLE
  } icrState_t;

  localparam int LINE_W_DEF = 256;
  localparam int BEAT_W_DEF = 64;
  localparam int BEATS      = LINE_W_DEF / BEAT_W_DEF;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W   = $clog2(LINE_W_DEF / 8);

  // Clear the byte-offset-within-line bits of an address.
  function automatic logic [63:0] lineAlign(input logic [63:0] addr, input int unsigned offW);
    lineAlign = addr & ~((64'd1 << offW) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Collects response beats into a full cache line, lowest-addressed beat in the low bits.
// One register slot per beat; the beat index selects which slot captures.
module icache_line_assembler
  import icache_refill_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beatValid,
  input  logic [BEAT_W-1:0] beatData,
  output logic [LINE_W-1:0] line,
  output logic              lastBeat
);

  localparam int NB    = LINE_W / BEAT_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [IDX_W-1:0]           beatIdx;
  logic [NB-1:0][BEAT_W-1:0]  beats;

  assign lastBeat = beatValid && (beatIdx == IDX_W'(NB - 1));
  assign line     = beats;

  // Beat index restarts at each request handshake and advances per accepted beat.
  always_ff @(posedge clk) begin
    if (reset || clear)  beatIdx <= '0;
    else if (beatValid)  beatIdx <= lastBeat ? '0 : beatIdx + 1'b1;
  end

  for (genvar b = 0; b < NB; b++) begin : gBeat
    logic [BEAT_W-1:0] slot;
    // Each slot captures only the beat addressed to it.
    always_ff @(posedge clk) begin
      if (reset)                                       slot <= '0;
      else if (beatValid && beatIdx == IDX_W'(b))      slot <= beatData;
    end
    assign beats[b] = slot;
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache refill sequencer: captures a miss, issues one line request, assembles
// the returned beats and writes the line into the cache. One refill outstanding.
// Optional build macro ICR_TIMEOUT_EN: abort a refill when beats stop arriving.
module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BEAT_W  = BEAT_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] missAddr_i,
  output logic              memReqValid_o,
  output logic [ADDR_W-1:0] memReqAddr_o,
  input  logic              memReqReady_i,
  input  logic              memRspValid_i,
  input  logic [BEAT_W-1:0] memRspData_i,
  output logic              wrEnable_o,
  output logic [ADDR_W-1:0] wrAddr_o,
  output logic [LINE_W-1:0] instBlock_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int OFF_W = $clog2(LINE_W / 8);

  icrState_t         state;
  logic [ADDR_W-1:0] lineAddr;
  logic [ADDR_W-1:0] alignedMiss;
  logic              discard;
  logic              beatValid;
  logic              fillClear;
  logic              lastBeat;
  logic              tmoHit;

  assign alignedMiss = ADDR_W'(lineAlign(64'(missAddr_i), OFF_W));
  // Beats outside FILL are an interface error and never reach the line register.
  assign beatValid   = (state == FILL) && memRspValid_i;
  assign fillClear   = (state == REQ) && memReqReady_i;

  icache_line_assembler #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) uAsm (
    .clk       (clk),
    .reset     (reset),
    .clear     (fillClear),
    .beatValid (beatValid),
    .beatData  (memRspData_i),
    .line      (instBlock_o),
    .lastBeat  (lastBeat)
  );

`ifdef ICR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmoCnt;

  // Abort once TIMEOUT consecutive FILL cycles have passed without a beat.
  assign tmoHit = (state == FILL) && !memRspValid_i && (tmoCnt == TMO_W'(TIMEOUT - 1));

  // Idle-cycle counter: only runs in FILL, restarts on every beat.
  always_ff @(posedge clk) begin
    if (reset || state != FILL || memRspValid_i) tmoCnt <= '0;
    else                                         tmoCnt <= tmoCnt + 1'b1;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)       timeout_o <= 1'b0;
    else if (tmoHit) timeout_o <= 1'b1;
  end
`else
  assign tmoHit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Refill FSM with registered outputs; the request stays valid through a flush
  // because the memory side cannot retract it, so a flush only marks the line discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lineAddr      <= '0;
      discard       <= 1'b0;
      memReqValid_o <= 1'b0;
      memReqAddr_o  <= '0;
      wrEnable_o    <= 1'b0;
      wrAddr_o      <= '0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_i && !flush_i) begin
            lineAddr      <= alignedMiss;
            memReqAddr_o  <= alignedMiss;
            memReqValid_o <= 1'b1;
            discard       <= 1'b0;
            busy_o        <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (flush_i) discard <= 1'b1;
          if (memReqReady_i) begin
            memReqValid_o <= 1'b0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (flush_i) discard <= 1'b1;
          if (lastBeat) begin
            if (discard || flush_i) begin
              state <= SETTLE;
            end else begin
              wrEnable_o <= 1'b1;
              wrAddr_o   <= lineAddr;
              state      <= WRITE;
            end
          end else if (tmoHit) begin
            state <= SETTLE;
          end
        end
        WRITE: begin
          wrEnable_o <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          // The cache's miss flag is stale here; wait a cycle before accepting a new one.
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
